spi_card_cmd_arbiter: RTL and testbench

Sequences SD-card SPI command issue between two requesters: the host register port (requester 0) and the stream command buffer (requester 1). Grants one command at a time to the SPI command engine through its `com_start`/`com_cmd`/`com_arg`/`com_rdy` interface. Supervises each command with a response timeout and bounded retry, then reports completion status to the owning requester. Sits between the command sources and the SPI commander in the card core.

---
 rtl/spi_card_cmd_arbiter_pkg.sv | 23 ++
 rtl/spi_card_cmd_arbiter_timeout_counter.sv | 34 +++
 rtl/spi_card_cmd_arbiter.sv | 179 +++++++++++++++++
 tb/tb_spi_card_cmd_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_card_cmd_arbiter_pkg.sv
// Shared definitions for the SD-card SPI command arbiter: FSM state
// encoding, completion status codes and command/argument widths.
package spi_card_cmd_arbiter_pkg;

    // Width of the command byte and of the argument carried with it
    localparam int CMD_W = 8;
    localparam int ARG_W = 24;

    // Arbiter sequencing states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RETRY = 3'd3,
        S_DONE  = 3'd4
    } arb_state_t;

    // Completion status reported alongside the done pulse
    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_OK_RETRY = 2'b01;
    localparam logic [1:0] ST_TIMEOUT  = 2'b10;

endpackage

// File: rtl/spi_card_cmd_arbiter_timeout_counter.sv
// Response-timeout counter for the command arbiter. Cleared when a command
// is launched, advances while the arbiter waits for the commander, and
// flags the last cycle of the wait window. Holds at all-ones instead of
// wrapping, so a stalled enable can never make the window appear to restart.
module spi_cmd_timeout_counter #(
    parameter int           W     = 16,
    parameter logic [W-1:0] LIMIT = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [W-1:0] LAST = LIMIT - W'(1);
    localparam logic [W-1:0] SAT  = '1;

    logic [W-1:0] count;

    // Count wait cycles; clear has priority, and the count saturates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != SAT)) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/spi_card_cmd_arbiter.sv
// Arbitrates SD-card SPI command issue between the host register port
// (requester 0) and the stream command buffer (requester 1). One command at
// a time is handed to the SPI commander; each is supervised by a response
// timeout with bounded retry, and completion status goes back to its owner.
module spi_card_cmd_arbiter
    import spi_card_cmd_arbiter_pkg::*;
#(
    parameter int                   TIMEOUT_W = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 16'd50000,
    parameter int                   MAX_RETRY = 2
) (
    input  logic             csi_clk,
    input  logic             rsi_reset,

    input  logic             req0_valid,
    input  logic [CMD_W-1:0] req0_cmd,
    input  logic [ARG_W-1:0] req0_arg,
    output logic             req0_ready,
    output logic             req0_done,

    input  logic             req1_valid,
    input  logic [CMD_W-1:0] req1_cmd,
    input  logic [ARG_W-1:0] req1_arg,
    output logic             req1_ready,
    output logic             req1_done,

    output logic [1:0]       done_status,

    output logic             com_start,
    output logic [CMD_W-1:0] com_cmd,
    output logic [ARG_W-1:0] com_arg,
    input  logic             com_rdy,

    output logic             busy,
    output logic             grant_id
);

    // Retry counter is wide enough for MAX_RETRY; a single bit when retry is off
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    arb_state_t state;
    arb_state_t state_n;

    logic [CMD_W-1:0]   cmd_q;
    logic [ARG_W-1:0]   arg_q;
    logic [RETRY_W-1:0] retry_cnt;

    logic       sel;
    logic       accept;
    logic       retry_inc;
    logic       status_load;
    logic [1:0] status_n;
    logic       tmr_clear;
    logic       tmr_enable;
    logic       tmr_expired;
    logic       bus_en;

    spi_cmd_timeout_counter #(
        .W     (TIMEOUT_W),
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk     (csi_clk),
        .rst     (rsi_reset),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    // State register
    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic, round-robin selection and all arbiter outputs
    always_comb begin
        state_n     = state;
        accept      = 1'b0;
        retry_inc   = 1'b0;
        status_load = 1'b0;
        status_n    = ST_OK;
        tmr_clear   = 1'b0;
        tmr_enable  = 1'b0;

        // Requester 1 wins when it is alone, or when both ask and 0 went last
        sel = req1_valid & (~req0_valid | ~grant_id);

        case (state)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept  = 1'b1;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmr_clear = 1'b1;
                state_n   = S_WAIT;
            end
            S_WAIT: begin
                tmr_enable = 1'b1;
                if (com_rdy) begin
                    status_load = 1'b1;
                    status_n    = (retry_cnt == '0) ? ST_OK : ST_OK_RETRY;
                    state_n     = S_DONE;
                end else if (tmr_expired) begin
                    if (retry_cnt < RETRY_LIMIT) begin
                        retry_inc = 1'b1;
                        state_n   = S_RETRY;
                    end else begin
                        status_load = 1'b1;
                        status_n    = ST_TIMEOUT;
                        state_n     = S_DONE;
                    end
                end
            end
            S_RETRY: begin
                state_n = S_ISSUE;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        req0_ready = (state == S_IDLE) & req0_valid & ~sel;
        req1_ready = (state == S_IDLE) & req1_valid & sel;

        req0_done  = (state == S_DONE) & ~grant_id;
        req1_done  = (state == S_DONE) & grant_id;

        com_start  = (state == S_ISSUE);
        busy       = (state != S_IDLE);

        // The command bus is OR-ed downstream, so it must read zero when idle
        bus_en     = (state == S_ISSUE) | (state == S_WAIT) | (state == S_RETRY);
        com_cmd    = bus_en ? cmd_q : '0;
        com_arg    = bus_en ? arg_q : '0;
    end

    // Capture the granted command and its owner at acceptance
    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            grant_id <= 1'b0;
            cmd_q    <= '0;
            arg_q    <= '0;
        end else if (accept) begin
            grant_id <= sel;
            cmd_q    <= sel ? req1_cmd : req0_cmd;
            arg_q    <= sel ? req1_arg : req0_arg;
        end
    end

    // Count re-issues of the current command; restarts with each new grant
    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            retry_cnt <= '0;
        end else if (accept) begin
            retry_cnt <= '0;
        end else if (retry_inc) begin
            retry_cnt <= retry_cnt + RETRY_W'(1);
        end
    end

    // Completion status is latched on entry to DONE and held until the next one
    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            done_status <= ST_OK;
        end else if (status_load) begin
            done_status <= status_n;
        end
    end

endmodule

// File: tb/tb_spi_card_cmd_arbiter.sv
// Directed bench for spi_card_cmd_arbiter with a short timeout (20 cycles)
// and two retries, so timeout and retry paths complete quickly.
module tb_spi_card_cmd_arbiter;

    logic        csi_clk = 1'b0;
    logic        rsi_reset;
    logic        req0_valid;
    logic [7:0]  req0_cmd;
    logic [23:0] req0_arg;
    logic        req0_ready;
    logic        req0_done;
    logic        req1_valid;
    logic [7:0]  req1_cmd;
    logic [23:0] req1_arg;
    logic        req1_ready;
    logic        req1_done;
    logic [1:0]  done_status;
    logic        com_start;
    logic [7:0]  com_cmd;
    logic [23:0] com_arg;
    logic        com_rdy;
    logic        busy;
    logic        grant_id;

    int checks = 0;
    int errors = 0;

    int cyc       = 0;
    int start_cnt = 0;
    int done0_cnt = 0;
    int done1_cnt = 0;
    int bus_dirty = 0;

    spi_card_cmd_arbiter #(
        .TIMEOUT_W (16),
        .TIMEOUT   (16'd20),
        .MAX_RETRY (2)
    ) dut (
        .csi_clk     (csi_clk),
        .rsi_reset   (rsi_reset),
        .req0_valid  (req0_valid),
        .req0_cmd    (req0_cmd),
        .req0_arg    (req0_arg),
        .req0_ready  (req0_ready),
        .req0_done   (req0_done),
        .req1_valid  (req1_valid),
        .req1_cmd    (req1_cmd),
        .req1_arg    (req1_arg),
        .req1_ready  (req1_ready),
        .req1_done   (req1_done),
        .done_status (done_status),
        .com_start   (com_start),
        .com_cmd     (com_cmd),
        .com_arg     (com_arg),
        .com_rdy     (com_rdy),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    // Free-running clock
    always #5 csi_clk = ~csi_clk;

    // Cycle index, advanced at every active edge
    always @(posedge csi_clk) cyc <= cyc + 1;

    // Passive monitor: count launches and done pulses, and flag a non-zero bus outside a transaction
    always @(negedge csi_clk) begin
        if (com_start) start_cnt <= start_cnt + 1;
        if (req0_done) done0_cnt <= done0_cnt + 1;
        if (req1_done) done1_cnt <= done1_cnt + 1;
        if ((!busy || req0_done || req1_done) && ((com_cmd != 8'h00) || (com_arg != 24'h000000)))
            bus_dirty <= bus_dirty + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present one request and hold it until accepted; acc is the cycle it was accepted in
    task automatic applyStimulus(input bit which, input logic [7:0] cmd, input logic [23:0] arg, output int acc);
        bit got;
        got = 1'b0;
        acc = -1;
        @(posedge csi_clk); #1;
        if (which) begin
            req1_valid = 1'b1; req1_cmd = cmd; req1_arg = arg;
        end else begin
            req0_valid = 1'b1; req0_cmd = cmd; req0_arg = arg;
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge csi_clk);
            if (which ? req1_ready : req0_ready) begin
                got = 1'b1;
                acc = cyc;
                break;
            end
        end
        @(posedge csi_clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checkOutput("accept_seen", 32'(got), 32'd1);
    endtask

    task automatic waitStart(output int s);
        bit got;
        got = 1'b0;
        s = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge csi_clk);
            if (com_start) begin
                got = 1'b1;
                s = cyc;
                break;
            end
        end
        checkOutput("com_start_seen", 32'(got), 32'd1);
    endtask

    task automatic waitDone(output int d);
        bit got;
        got = 1'b0;
        d = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge csi_clk);
            if (req0_done || req1_done) begin
                got = 1'b1;
                d = cyc;
                break;
            end
        end
        checkOutput("done_seen", 32'(got), 32'd1);
    endtask

    // Drive a one-cycle com_rdy during cycle at_cyc
    task automatic pulseRdy(input int at_cyc);
        for (int i = 0; (i < 200) && (cyc < at_cyc); i++) begin
            @(posedge csi_clk); #1;
        end
        com_rdy = 1'b1;
        @(posedge csi_clk); #1;
        com_rdy = 1'b0;
    endtask

    // Let monitor updates from the previous negedge settle before reading them
    task automatic settle();
        @(posedge csi_clk); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acc, s, s2, d, a1, a2;
        int b_start, b_d0, b_d1;
        bit found;

        rsi_reset  = 1'b1;
        req0_valid = 1'b0; req0_cmd = 8'h00; req0_arg = 24'h0;
        req1_valid = 1'b0; req1_cmd = 8'h00; req1_arg = 24'h0;
        com_rdy    = 1'b0;

        // Reset values
        #12;
        checkOutput("reset_ctrl", 32'({com_start, busy, grant_id, done_status, req0_done, req1_done, req0_ready, req1_ready}), 32'd0);
        checkOutput("reset_cmd", 32'(com_cmd), 32'd0);
        checkOutput("reset_arg", 32'(com_arg), 32'd0);
        @(negedge csi_clk);
        rsi_reset = 1'b0;

        // Both valid from reset: requester 1 first, then requester 0
        @(posedge csi_clk); #1;
        req0_valid = 1'b1; req0_cmd = 8'h11; req0_arg = 24'hAAAAAA;
        req1_valid = 1'b1; req1_cmd = 8'h22; req1_arg = 24'h555555;
        @(negedge csi_clk);
        checkOutput("rr_first_ready", 32'({req0_ready, req1_ready}), 32'd1);
        a1 = cyc;
        @(posedge csi_clk); #1;
        req1_valid = 1'b0;
        waitStart(s);
        checkOutput("rr_first_latency", 32'(s - a1), 32'd1);
        checkOutput("rr_first_cmd", 32'(com_cmd), 32'h22);
        checkOutput("rr_first_arg", 32'(com_arg), 32'h555555);
        pulseRdy(s + 1);
        found = 1'b0;
        a2 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge csi_clk);
            if (req0_ready) begin
                found = 1'b1;
                a2 = cyc;
                break;
            end
        end
        checkOutput("rr_second_ready", 32'(found), 32'd1);
        checkOutput("rr_accept_spacing", 32'(a2 - a1), 32'd4);
        checkOutput("rr_grant_before_second", 32'(grant_id), 32'd1);
        @(posedge csi_clk); #1;
        req0_valid = 1'b0;
        waitStart(s2);
        checkOutput("rr_second_cmd", 32'(com_cmd), 32'h11);
        checkOutput("rr_second_arg", 32'(com_arg), 32'hAAAAAA);
        pulseRdy(s2 + 1);
        waitDone(d);
        checkOutput("rr_second_done_cycle", 32'(d - s2), 32'd2);
        settle();
        checkOutput("rr_done_counts", 32'({done0_cnt[7:0], done1_cnt[7:0]}), 32'h0101);
        checkOutput("rr_start_count", 32'(start_cnt), 32'd2);
        checkOutput("rr_final_grant", 32'(grant_id), 32'd0);

        // Single command from requester 0, response 10 cycles after launch
        b_start = start_cnt; b_d0 = done0_cnt; b_d1 = done1_cnt;
        applyStimulus(1'b0, 8'h51, 24'h000200, acc);
        waitStart(s);
        checkOutput("basic_latency", 32'(s - acc), 32'd1);
        checkOutput("basic_cmd", 32'(com_cmd), 32'h51);
        checkOutput("basic_arg", 32'(com_arg), 32'h000200);
        checkOutput("basic_busy", 32'(busy), 32'd1);
        pulseRdy(s + 10);
        waitDone(d);
        checkOutput("basic_done_cycle", 32'(d - s), 32'd11);
        checkOutput("basic_done_owner", 32'({req0_done, req1_done}), 32'd2);
        checkOutput("basic_status", 32'(done_status), 32'd0);
        @(negedge csi_clk);
        checkOutput("basic_idle_after", 32'({busy, com_start}), 32'd0);
        settle();
        checkOutput("basic_starts", 32'(start_cnt - b_start), 32'd1);
        checkOutput("basic_dones", 32'({8'(done0_cnt - b_d0), 8'(done1_cnt - b_d1)}), 32'h0100);

        // No response at all: three launches, then timeout failure
        b_start = start_cnt;
        applyStimulus(1'b1, 8'h4D, 24'hABCDEF, acc);
        waitStart(s);
        checkOutput("to_start1_cycle", 32'(s - acc), 32'd1);
        checkOutput("to_start1_cmdarg", {com_cmd, com_arg}, 32'h4DABCDEF);
        waitStart(s);
        checkOutput("to_start2_cycle", 32'(s - acc), 32'd23);
        checkOutput("to_start2_cmdarg", {com_cmd, com_arg}, 32'h4DABCDEF);
        waitStart(s);
        checkOutput("to_start3_cycle", 32'(s - acc), 32'd45);
        checkOutput("to_start3_cmdarg", {com_cmd, com_arg}, 32'h4DABCDEF);
        waitDone(d);
        checkOutput("to_done_cycle", 32'(d - acc), 32'd66);
        checkOutput("to_done_owner", 32'({req0_done, req1_done}), 32'd1);
        checkOutput("to_status", 32'(done_status), 32'd2);
        settle();
        checkOutput("to_starts", 32'(start_cnt - b_start), 32'd3);

        // Response only during the second attempt
        b_start = start_cnt;
        applyStimulus(1'b0, 8'h58, 24'h00ABCD, acc);
        waitStart(s);
        waitStart(s2);
        checkOutput("retry_spacing", 32'(s2 - s), 32'd22);
        pulseRdy(s2 + 5);
        waitDone(d);
        checkOutput("retry_done_cycle", 32'(d - s2), 32'd6);
        checkOutput("retry_status", 32'(done_status), 32'd1);
        settle();
        checkOutput("retry_starts", 32'(start_cnt - b_start), 32'd2);
        repeat (3) @(posedge csi_clk);
        #1;
        checkOutput("status_hold_idle", 32'(done_status), 32'd1);

        // Response in the same cycle the window expires: success, no retry
        b_start = start_cnt;
        applyStimulus(1'b1, 8'h40, 24'h0001AA, acc);
        waitStart(s);
        pulseRdy(s + 20);
        waitDone(d);
        checkOutput("edge_done_cycle", 32'(d - s), 32'd21);
        checkOutput("edge_status", 32'(done_status), 32'd0);
        settle();
        checkOutput("edge_starts", 32'(start_cnt - b_start), 32'd1);

        // Stray com_rdy while idle is ignored
        b_start = start_cnt; b_d0 = done0_cnt; b_d1 = done1_cnt;
        com_rdy = 1'b1;
        @(posedge csi_clk); #1;
        com_rdy = 1'b0;
        repeat (3) @(negedge csi_clk);
        checkOutput("stray_busy", 32'(busy), 32'd0);
        settle();
        checkOutput("stray_activity", 32'({8'(start_cnt - b_start), 8'(done0_cnt - b_d0), 8'(done1_cnt - b_d1)}), 32'd0);

        // Reset during WAIT aborts silently; the next request is served normally
        b_d0 = done0_cnt; b_d1 = done1_cnt;
        applyStimulus(1'b1, 8'h77, 24'h314159, acc);
        waitStart(s);
        repeat (3) @(posedge csi_clk);
        #3;
        rsi_reset = 1'b1;
        #1;
        checkOutput("abort_ctrl", 32'({com_start, busy, grant_id, done_status, req0_done, req1_done}), 32'd0);
        checkOutput("abort_bus", 32'({com_cmd, com_arg}), 32'd0);
        repeat (2) @(negedge csi_clk);
        rsi_reset = 1'b0;
        repeat (3) @(posedge csi_clk);
        #1;
        checkOutput("abort_no_done", 32'({8'(done0_cnt - b_d0), 8'(done1_cnt - b_d1)}), 32'd0);
        checkOutput("abort_idle", 32'(busy), 32'd0);
        b_d0 = done0_cnt;
        applyStimulus(1'b0, 8'h4C, 24'h000010, acc);
        waitStart(s);
        checkOutput("post_reset_cmdarg", {com_cmd, com_arg}, 32'h4C000010);
        pulseRdy(s + 3);
        waitDone(d);
        checkOutput("post_reset_done_cycle", 32'(d - s), 32'd4);
        checkOutput("post_reset_status", 32'(done_status), 32'd0);
        settle();
        checkOutput("post_reset_done0", 32'(done0_cnt - b_d0), 32'd1);
        checkOutput("bus_zero_outside_txn", 32'(bus_dirty), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
